// File: rtl/morse_key_classifier_pkg.sv
// rtl/morse_key_classifier_pkg.sv - shared FSM states, symbol codes and sizing helpers for the Morse key front end
package morse_key_classifier_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_REL = 3'd0,
    ST_IDLE     = 3'd1,
    ST_PRESS    = 3'd2,
    ST_GAP      = 3'd3,
    ST_GAP_LTR  = 3'd4
  } state_t;

  // Symbol codes shared with morse_code_encoder / sequence_producer
  typedef enum logic [1:0] {
    SYM_DOT   = 2'b00,
    SYM_DASH  = 2'b01,
    SYM_SPACE = 2'b10,
    SYM_END   = 2'b11
  } sym_t;

  function automatic int units_to_cycles(input int units, input int unit_cycles);
    return units * unit_cycles;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// rtl/key_sync_debounce.sv - Key synchronizer plus debouncer, enabled by MORSE_KEY_DEBOUNCE_EN
module key_sync_debounce
  import morse_key_classifier_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key,
  output logic Kd
);

`ifdef MORSE_KEY_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int DB_EFF = DB_EN ? DEBOUNCE_CYCLES : 0;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  // Synchronizer is deliberately not reset so a key held across Reset stays visible
  always_ff @(posedge Clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], Key};
  end
  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DB_EFF > 0) begin : g_db
      localparam int             CW     = cnt_width(DB_EFF);
      localparam logic [CW-1:0] C_LAST = CW'(DB_EFF - 1);
      logic          r_kd;
      logic [CW-1:0] r_cnt;

      // Reset adopts the current level so a press spanning Reset is not seen as a new edge
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_kd  <= w_sync;
          r_cnt <= '0;
        end else if (w_sync == r_kd) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_kd  <= w_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      assign Kd = r_kd;
    end else begin : g_nodb
      logic w_unused_reset;
      assign w_unused_reset = Reset;
      assign Kd = w_sync;
    end
  endgenerate

endmodule

// File: rtl/morse_key_classifier.sv
// rtl/morse_key_classifier.sv - classifies debounced key presses/gaps into Dot/Dash/Space/EndSeq pulses (MORSE_KEY_DEBOUNCE_EN selects debouncing)
module morse_key_classifier
  import morse_key_classifier_pkg::*;
#(
  parameter int UNIT_CYCLES     = 50000,
  parameter int DASH_UNITS      = 2,
  parameter int LETTER_UNITS    = 3,
  parameter int WORD_UNITS      = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key,
  output logic Dot,
  output logic Dash,
  output logic Space,
  output logic EndSeq,
  output logic Keying
);

  localparam int                CNT_W    = $clog2(WORD_UNITS * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_DASH   = CNT_W'(units_to_cycles(DASH_UNITS, UNIT_CYCLES));
  localparam logic [CNT_W-1:0] C_LETTER = CNT_W'(units_to_cycles(LETTER_UNITS, UNIT_CYCLES));
  localparam logic [CNT_W-1:0] C_WORD   = CNT_W'(units_to_cycles(WORD_UNITS, UNIT_CYCLES));

  logic             w_kd;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  key_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .Clk  (Clk),
    .Reset(Reset),
    .Key  (Key),
    .Kd   (w_kd)
  );

  // w_cnt_inc is the length of the current press/gap including this cycle
  assign w_cnt_inc = (r_cnt == C_WORD) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_WAIT_REL;
      r_cnt   <= '0;
      Dot     <= 1'b0;
      Dash    <= 1'b0;
      Space   <= 1'b0;
      EndSeq  <= 1'b0;
      Keying  <= 1'b0;
    end else begin
      Dot    <= 1'b0;
      Dash   <= 1'b0;
      Space  <= 1'b0;
      EndSeq <= 1'b0;
      Keying <= w_kd;
      case (r_state)
        ST_WAIT_REL: if (!w_kd) r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_kd) begin
            r_state <= ST_PRESS;
            r_cnt   <= '0;
          end
        end
        ST_PRESS: begin
          if (w_kd) begin
            if (r_cnt != C_DASH) r_cnt <= w_cnt_inc;
          end else begin
            Dash    <= (w_cnt_inc >= C_DASH);
            Dot     <= (w_cnt_inc <  C_DASH);
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end
        end
        ST_GAP: begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == C_LETTER) begin
            Space   <= 1'b1;
            r_state <= ST_GAP_LTR;
          end
          if (w_kd) begin
            r_state <= ST_PRESS;
            r_cnt   <= '0;
          end
        end
        ST_GAP_LTR: begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == C_WORD) begin
            EndSeq  <= 1'b1;
            r_state <= ST_IDLE;
          end
          if (w_kd) begin
            r_state <= ST_PRESS;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_WAIT_REL;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_classifier.sv
// tb/tb_morse_key_classifier.sv - self-checking bench for morse_key_classifier (honours MORSE_KEY_DEBOUNCE_EN)
module tb_morse_key_classifier;

  localparam int UNIT   = 10;
  localparam int DASH_U = 2;
  localparam int LET_U  = 3;
  localparam int WORD_U = 7;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
`ifdef MORSE_KEY_DEBOUNCE_EN
  localparam int DEB_EFF = DEB;
`else
  localparam int DEB_EFF = 0;
`endif
  localparam int DASH_C = DASH_U * UNIT;
  localparam int LET_C  = LET_U * UNIT;
  localparam int WORD_C = WORD_U * UNIT;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Key = 1'b0;
  logic Dot, Dash, Space, EndSeq, Keying;

  int total = 0;
  int bad = 0;
  bit key_q[$];
  int obs_q[$];
  bit keying_q[$];
  bit k0_g = 1'b0;

  morse_key_classifier #(
    .UNIT_CYCLES    (UNIT),
    .DASH_UNITS     (DASH_U),
    .LETTER_UNITS   (LET_U),
    .WORD_UNITS     (WORD_U),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Key   (Key),
    .Dot   (Dot),
    .Dash  (Dash),
    .Space (Space),
    .EndSeq(EndSeq),
    .Keying(Keying)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Events are recorded as cycle*4 + kind (0 Dot, 1 Dash, 2 Space, 3 EndSeq)
  task automatic step(input bit k);
    int idx;
    Key = k;
    @(posedge Clk);
    key_q.push_back(k);
    idx = key_q.size() - 1;
    @(negedge Clk);
    chk("onehot", int'($countones({Dot, Dash, Space, EndSeq}) <= 1), 1);
    if (Dot)    obs_q.push_back(idx * 4 + 0);
    if (Dash)   obs_q.push_back(idx * 4 + 1);
    if (Space)  obs_q.push_back(idx * 4 + 2);
    if (EndSeq) obs_q.push_back(idx * 4 + 3);
    keying_q.push_back(Keying);
  endtask

  task automatic seg(input bit k, input int n);
    repeat (n) step(k);
  endtask

  task automatic do_reset(input bit k, input int n);
    Reset = 1'b1;
    Key = k;
    repeat (n) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outs", int'({Dot, Dash, Space, EndSeq, Keying}), 0);
    Reset = 1'b0;
    key_q.delete();
    obs_q.delete();
    keying_q.delete();
    k0_g = k;
  endtask

  // Synchronized key level available after edge t
  function automatic bit yv(input int t);
    int i;
    i = t - SYNC + 1;
    if (i < 0) return k0_g;
    return key_q[i];
  endfunction

  task automatic compare(input string tag);
    bit s[$];
    int e_q[$];
    bit kd;
    bit timed;
    int n, i, j, kmis;
    n = key_q.size();
    kd = k0_g;
    // s[t]: accepted key level as seen by the classifier at edge t
    for (int t = 0; t < n; t++) begin
      bit all_eq;
      s.push_back(kd);
      if (DEB_EFF == 0) begin
        kd = yv(t);
      end else begin
        all_eq = 1'b1;
        for (int d = 2; d <= DEB_EFF; d++)
          if (yv(t - d) != yv(t - 1)) all_eq = 1'b0;
        if (all_eq) kd = yv(t - 1);
      end
    end
    // Run-length classification; a press already held at reset is never classified
    i = 0;
    timed = 1'b0;
    while (i < n) begin
      j = i;
      while (j < n && s[j] == s[i]) j++;
      if (s[i]) begin
        timed = (i != 0);
        if (timed && j < n) e_q.push_back(j * 4 + (((j - i) >= DASH_C) ? 1 : 0));
      end else if (timed) begin
        if (i + LET_C <= j && i + LET_C < n)   e_q.push_back((i + LET_C) * 4 + 2);
        if (i + WORD_C <= j && i + WORD_C < n) e_q.push_back((i + WORD_C) * 4 + 3);
      end
      i = j;
    end
    chk({tag, "_count"}, obs_q.size(), e_q.size());
    for (int k = 0; k < e_q.size() && k < obs_q.size(); k++)
      chk({tag, "_event"}, obs_q[k], e_q[k]);
    kmis = 0;
    for (int t = 0; t < n; t++)
      if (keying_q[t] != s[t]) kmis++;
    chk({tag, "_keying"}, kmis, 0);
  endtask

  initial begin
    do_reset(1'b0, 4);
    seg(1'b1, 15); seg(1'b0, 100);
    compare("dot");

    do_reset(1'b0, 2);
    seg(1'b1, 25); seg(1'b0, 100);
    compare("dash");

    do_reset(1'b0, 2);
    seg(1'b1, 5);  seg(1'b0, 12);
    seg(1'b1, 25); seg(1'b0, 12);
    seg(1'b1, 5);  seg(1'b0, 12);
    seg(1'b1, 5);  seg(1'b0, 35);
    seg(1'b0, 60);
    compare("letter");

    do_reset(1'b0, 2);
    for (int c = 0; c < 50; c++) step(c % 3 == 0);
    seg(1'b0, 30);
    compare("glitch");
`ifdef MORSE_KEY_DEBOUNCE_EN
    chk("glitch_silent", obs_q.size(), 0);
`endif

    do_reset(1'b0, 2);
    seg(1'b1, 15);
    do_reset(1'b1, 1);
    seg(1'b1, 30); seg(1'b0, 100);
    seg(1'b1, 8);  seg(1'b0, 90);
    compare("rst_press");

    do_reset(1'b0, 2);
    seg(1'b1, 500); seg(1'b0, 100);
    compare("held");

    do_reset(1'b0, 2);
    seg(1'b1, 19); seg(1'b0, 29);
    seg(1'b1, 20); seg(1'b0, 30);
    seg(1'b1, 21); seg(1'b0, 69);
    seg(1'b1, 5);  seg(1'b0, 70);
    seg(1'b1, 5);  seg(1'b0, 71);
    seg(1'b1, 5);  seg(1'b0, 80);
    compare("bound");

    for (int r = 0; r < 3; r++) begin
      do_reset(1'b0, 2);
      for (int p = 0; p < 12; p++) begin
        seg(1'b1, $urandom_range(1, 45));
        seg(1'b0, $urandom_range(1, 90));
      end
      seg(1'b0, 80);
      compare("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
